// File: rtl/point_out_serializer_if.sv
// Bus between the point output serializer and its consumer: the captured result
// and done flag coming in, the nibble-serial valid/ready stream going out.
interface point_out_serializer_if #(
    parameter int SIZE  = 32,
    parameter int NIB_W = 4
);
    logic             i_done;
    logic [SIZE-1:0]  i_x;
    logic [SIZE-1:0]  i_y;
    logic             i_ready;
    logic             o_valid;
    logic [NIB_W-1:0] o_x_nib;
    logic [NIB_W-1:0] o_y_nib;
    logic             o_last;
    logic             o_busy;
    logic             o_finished;

    // master: the serializer, which sources the nibble stream
    modport master (
        input  i_done, i_x, i_y, i_ready,
        output o_valid, o_x_nib, o_y_nib, o_last, o_busy, o_finished
    );

    // slave: controller plus downstream sink
    modport slave (
        output i_done, i_x, i_y, i_ready,
        input  o_valid, o_x_nib, o_y_nib, o_last, o_busy, o_finished
    );
endinterface

// File: rtl/point_out_serializer.sv
// Captures the final (kPx, kPy) on the controller's done flag and streams both
// coordinates out LSB nibble first over a valid/ready handshake.
module point_out_serializer #(
    parameter int SIZE  = 32,
    parameter int NIB_W = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    point_out_serializer_if.master bus
);
    // SIZE must be a multiple of NIB_W; NIB_CNT is derived only.
    localparam int NIB_CNT = SIZE / NIB_W;
    localparam int CNT_W   = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB_CNT - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(NIB_CNT - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t          r_state;
    logic [SIZE-1:0] r_x_sh;
    logic [SIZE-1:0] r_y_sh;
    logic [CNT_W-1:0] r_cnt;
    logic            r_valid;
    logic            r_last;
    logic            r_busy;
    logic            r_finished;

    logic w_hs;
    assign w_hs = r_valid & bus.i_ready;

    // NOTE: every register here, shift registers included, is async-reset so no
    // half-sent beat survives a reset; all state uses non-blocking assignment.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= ST_IDLE;
            r_x_sh     <= '0;
            r_y_sh     <= '0;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_done) begin
                        r_x_sh  <= bus.i_x;
                        r_y_sh  <= bus.i_y;
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_last  <= (NIB_CNT == 1);
                        r_state <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (w_hs) begin
                        r_x_sh <= r_x_sh >> NIB_W;
                        r_y_sh <= r_y_sh >> NIB_W;
                        if (r_cnt == LAST_CNT) begin
                            r_cnt      <= '0;
                            r_valid    <= 1'b0;
                            r_busy     <= 1'b0;
                            r_last     <= 1'b0;
                            r_finished <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_cnt  <= r_cnt + CNT_W'(1);
                            r_last <= (r_cnt == PRE_LAST);
                        end
                    end
                end

                // Held done flag parks here; only a low done rearms.
                ST_DONE: begin
                    if (!bus.i_done) begin
                        r_finished <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end

                default: begin
                    r_valid    <= 1'b0;
                    r_busy     <= 1'b0;
                    r_last     <= 1'b0;
                    r_finished <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Shift registers have drained to zero outside SEND, so nibbles read 0 there.
    assign bus.o_valid    = r_valid;
    assign bus.o_x_nib    = r_x_sh[NIB_W-1:0];
    assign bus.o_y_nib    = r_y_sh[NIB_W-1:0];
    assign bus.o_last     = r_last;
    assign bus.o_busy     = r_busy;
    assign bus.o_finished = r_finished;
endmodule

// File: tb/tb_point_out_serializer.sv
// Directed bench for point_out_serializer: 32-bit build plus a SIZE=8 build on
// the same clock and reset.
module tb_point_out_serializer;
    logic i_clk;
    logic i_rst;
    int   n_total = 0;
    int   n_bad   = 0;

    point_out_serializer_if #(.SIZE(32), .NIB_W(4)) bus32 ();
    point_out_serializer_if #(.SIZE(8),  .NIB_W(4)) bus8 ();

    point_out_serializer #(.SIZE(32), .NIB_W(4)) u_dut32 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus32)
    );

    point_out_serializer #(.SIZE(8), .NIB_W(4)) u_dut8 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus8)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".valid"},    32'(bus32.o_valid),    32'd0);
        check({tag, ".busy"},     32'(bus32.o_busy),     32'd0);
        check({tag, ".last"},     32'(bus32.o_last),     32'd0);
        check({tag, ".finished"}, 32'(bus32.o_finished), 32'd0);
        check({tag, ".xnib"},     32'(bus32.o_x_nib),    32'd0);
        check({tag, ".ynib"},     32'(bus32.o_y_nib),    32'd0);
    endtask

    // Drop done for one cycle and confirm the block went back to IDLE.
    task automatic rearm(input string tag);
        bus32.i_done = 1'b0;
        @(negedge i_clk);
        check({tag, ".rearm_fin"},   32'(bus32.o_finished), 32'd0);
        check({tag, ".rearm_valid"}, 32'(bus32.o_valid),    32'd0);
    endtask

    // Raise done with (x, y) and drain eight beats using ready pattern rpat
    // (bit i drives ready for cycle i). If zero_after > 0, i_x is cleared once
    // that many beats have been accepted; expected nibbles always come from x.
    task automatic run_xfer(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic [15:0] rpat, input int zero_after);
        int         beats;
        logic       pv;
        logic       pr;
        logic [3:0] px;
        logic [3:0] py;
        beats = 0;
        pv = 1'b0;
        pr = 1'b0;
        px = '0;
        py = '0;
        bus32.i_x    = x;
        bus32.i_y    = y;
        bus32.i_done = 1'b1;
        for (int i = 0; i < 64 && beats < 8; i++) begin
            @(negedge i_clk);
            if (i == 0) check({tag, ".latency"}, 32'(bus32.o_valid), 32'd1);
            if (pv && !pr) begin
                check($sformatf("%s.hold_x%0d", tag, i), 32'(bus32.o_x_nib), 32'(px));
                check($sformatf("%s.hold_y%0d", tag, i), 32'(bus32.o_y_nib), 32'(py));
            end
            bus32.i_ready = rpat[i % 16];
            if (bus32.o_valid && bus32.i_ready) begin
                check($sformatf("%s.x%0d", tag, beats), 32'(bus32.o_x_nib), 32'(x[4*beats +: 4]));
                check($sformatf("%s.y%0d", tag, beats), 32'(bus32.o_y_nib), 32'(y[4*beats +: 4]));
                check($sformatf("%s.last%0d", tag, beats), 32'(bus32.o_last), 32'(beats == 7));
                check($sformatf("%s.busy%0d", tag, beats), 32'(bus32.o_busy), 32'd1);
                beats++;
                if (beats == zero_after) bus32.i_x = '0;
            end
            pv = bus32.o_valid;
            pr = bus32.i_ready;
            px = bus32.o_x_nib;
            py = bus32.o_y_nib;
        end
        check({tag, ".beats"}, 32'(beats), 32'd8);
        @(negedge i_clk);
        check({tag, ".end_valid"}, 32'(bus32.o_valid),    32'd0);
        check({tag, ".end_fin"},   32'(bus32.o_finished), 32'd1);
        check({tag, ".end_busy"},  32'(bus32.o_busy),     32'd0);
    endtask

    initial begin
        logic [3:0] xt [8];
        logic [3:0] yt [8];
        xt = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
        yt = '{4'h0, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9};

        i_rst         = 1'b0;
        bus32.i_done  = 1'b0;
        bus32.i_x     = '0;
        bus32.i_y     = '0;
        bus32.i_ready = 1'b0;
        bus8.i_done   = 1'b0;
        bus8.i_x      = '0;
        bus8.i_y      = '0;
        bus8.i_ready  = 1'b0;
        #1;
        check_idle_outputs("reset");
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;

        // Scenario 1: ready held high, hand-computed nibble tables.
        bus32.i_x     = 32'h1234_5678;
        bus32.i_y     = 32'h9ABC_DEF0;
        bus32.i_done  = 1'b1;
        bus32.i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge i_clk);
            check($sformatf("s1.valid%0d", k), 32'(bus32.o_valid), 32'd1);
            check($sformatf("s1.x%0d", k),     32'(bus32.o_x_nib), 32'(xt[k]));
            check($sformatf("s1.y%0d", k),     32'(bus32.o_y_nib), 32'(yt[k]));
            check($sformatf("s1.last%0d", k),  32'(bus32.o_last),  32'(k == 7));
        end
        @(negedge i_clk);
        check("s1.fin",   32'(bus32.o_finished), 32'd1);
        check("s1.valid", 32'(bus32.o_valid),    32'd0);

        // Scenario 3: held done never retriggers; rearm then all-F transfer.
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            check($sformatf("s3.hold_fin%0d", k),   32'(bus32.o_finished), 32'd1);
            check($sformatf("s3.hold_valid%0d", k), 32'(bus32.o_valid),    32'd0);
        end
        rearm("s3");
        run_xfer("s3", 32'hFFFF_FFFF, 32'h0000_0000, 16'hFFFF, 0);

        // Scenario 2: ready 1,0,0,1,0,1,0,1,1,0,0,1,0,1,0,1.
        rearm("s2");
        run_xfer("s2", 32'h1234_5678, 32'h9ABC_DEF0, 16'b1010_1001_1010_1001, 0);

        // Scenario 4: i_x cleared after the 3rd beat must not disturb the stream.
        rearm("s4");
        run_xfer("s4", 32'h1234_5678, 32'h9ABC_DEF0, 16'hFFFF, 3);

        // Scenario 5: async reset mid-cycle after the 4th beat.
        rearm("s5");
        bus32.i_x     = 32'h1234_5678;
        bus32.i_y     = 32'h9ABC_DEF0;
        bus32.i_done  = 1'b1;
        bus32.i_ready = 1'b1;
        repeat (5) @(negedge i_clk);
        check("s5.pre_x", 32'(bus32.o_x_nib), 32'h4);
        @(posedge i_clk);
        #3;
        i_rst = 1'b0;
        #1;
        check_idle_outputs("s5.async");
        @(negedge i_clk);
        check_idle_outputs("s5.held");
        i_rst = 1'b1;
        run_xfer("s5.restart", 32'h1234_5678, 32'h9ABC_DEF0, 16'hFFFF, 0);

        // Scenario 6: SIZE=8 build, two beats.
        bus8.i_x     = 8'hA5;
        bus8.i_y     = 8'h3C;
        bus8.i_done  = 1'b1;
        bus8.i_ready = 1'b1;
        @(negedge i_clk);
        check("s6.valid0", 32'(bus8.o_valid), 32'd1);
        check("s6.x0",     32'(bus8.o_x_nib), 32'h5);
        check("s6.y0",     32'(bus8.o_y_nib), 32'hC);
        check("s6.last0",  32'(bus8.o_last),  32'd0);
        @(negedge i_clk);
        check("s6.valid1", 32'(bus8.o_valid), 32'd1);
        check("s6.x1",     32'(bus8.o_x_nib), 32'hA);
        check("s6.y1",     32'(bus8.o_y_nib), 32'h3);
        check("s6.last1",  32'(bus8.o_last),  32'd1);
        @(negedge i_clk);
        check("s6.fin",    32'(bus8.o_finished), 32'd1);
        check("s6.valid",  32'(bus8.o_valid),    32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
